// File: rtl/dac_sched_pkg.sv
// Shared constants, channel state encoding and sample-format helper for the DAC stream scheduler.
package dac_sched_pkg;

  localparam int DW = 14;
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2,
    UNDERRUN = 2'd3
  } ch_state_e;

  typedef enum logic [1:0] {
    SRC_STREAM = 2'd0,
    SRC_CSR    = 2'd1,
    SRC_RAMP   = 2'd2
  } src_mode_e;

  // Two's complement to offset binary is an MSB flip; unsigned samples pass through.
  function automatic logic [DW-1:0] to_offset_bin(input logic [DW-1:0] s, input logic is_signed);
    if (is_signed) begin
      return {~s[DW-1], s[DW-2:0]};
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Per-channel synchronous sample FIFO with occupancy level and synchronous flush.
module dac_sample_fifo #(
  parameter int W  = 14,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rptr];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers and level; flush empties the FIFO in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dac_stream_scheduler.sv
// Two-channel DAC sample scheduler: FIFO buffering, source select, shared rate tick, underrun handling.
// Optional DAC_TEST_RAMP_EN adds a cfg_ramp input selecting a per-tick sawtooth test source.
module dac_stream_scheduler
  import dac_sched_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 16,
  parameter int UCNT_W  = 16
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               s1_valid,
  output logic               s1_ready,
  input  logic [DW-1:0]      s1_data,
  input  logic               s2_valid,
  output logic               s2_ready,
  input  logic [DW-1:0]      s2_data,
  input  logic [1:0]         cfg_en,
  input  logic [1:0]         cfg_src,
  input  logic               cfg_signed,
  input  logic               cfg_hold,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [FIFO_AW:0]   cfg_prime,
  input  logic [DW-1:0]      csr_data1,
  input  logic [DW-1:0]      csr_data2,
`ifdef DAC_TEST_RAMP_EN
  input  logic [1:0]         cfg_ramp,
`endif
  output logic [DW-1:0]      data1,
  output logic               wrt1_en,
  output logic [DW-1:0]      data2,
  output logic               wrt2_en,
  output logic [UCNT_W-1:0]  ucnt1,
  output logic [UCNT_W-1:0]  ucnt2,
  input  logic               ucnt_clr,
  output logic [1:0]         state1,
  output logic [1:0]         state2
);

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [FIFO_AW:0]  prime_eff;

  logic              s_valid  [2];
  logic [DW-1:0]     s_data   [2];
  logic [DW-1:0]     csr_data [2];
  logic              ready_a  [2];
  logic [DW-1:0]     data_a   [2];
  logic              wrt_a    [2];
  logic [UCNT_W-1:0] ucnt_a   [2];
  logic [1:0]        state_a  [2];

  assign s_valid[0]  = s1_valid;
  assign s_valid[1]  = s2_valid;
  assign s_data[0]   = s1_data;
  assign s_data[1]   = s2_data;
  assign csr_data[0] = csr_data1;
  assign csr_data[1] = csr_data2;

  assign s1_ready = ready_a[0];
  assign s2_ready = ready_a[1];
  assign data1    = data_a[0];
  assign data2    = data_a[1];
  assign wrt1_en  = wrt_a[0];
  assign wrt2_en  = wrt_a[1];
  assign ucnt1    = ucnt_a[0];
  assign ucnt2    = ucnt_a[1];
  assign state1   = state_a[0];
  assign state2   = state_a[1];

  assign tick      = (div_cnt >= cfg_div);
  assign prime_eff = (cfg_prime == '0) ? (FIFO_AW+1)'(1) : cfg_prime;

  // Shared rate divider so both channels update on the same edge.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

`ifdef DAC_TEST_RAMP_EN
  logic [DW-1:0] ramp_cnt;

  // Free-running sawtooth advanced once per tick.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      ramp_cnt <= '0;
    end else if (tick) begin
      ramp_cnt <= ramp_cnt + DW'(1);
    end else begin
      ramp_cnt <= ramp_cnt;
    end
  end
`endif

  for (genvar i = 0; i < 2; i++) begin : g_ch
    src_mode_e         mode;
    src_mode_e         mode_q;
    ch_state_e         st;
    ch_state_e         st_n;
    logic              active;
    logic              stream;
    logic              prime_ok;
    logic              ready;
    logic              push;
    logic              pop;
    logic              flush;
    logic              full;
    logic              empty;
    logic              under;
    logic              wrt_q;
    logic [FIFO_AW:0]  level;
    logic [DW-1:0]     fifo_out;
    logic [DW-1:0]     static_val;
    logic [DW-1:0]     data_q;
    logic [DW-1:0]     data_n;
    logic [UCNT_W-1:0] ucnt_q;

`ifdef DAC_TEST_RAMP_EN
    assign mode = cfg_ramp[i] ? SRC_RAMP : (cfg_src[i] ? SRC_CSR : SRC_STREAM);
    assign static_val = (mode == SRC_RAMP) ? ((i == 0) ? ramp_cnt : ramp_cnt + MID)
                                           : to_offset_bin(csr_data[i], cfg_signed);
`else
    assign mode = cfg_src[i] ? SRC_CSR : SRC_STREAM;
    assign static_val = to_offset_bin(csr_data[i], cfg_signed);
`endif

    // A source change looks like a one-cycle disable, which routes the channel through IDLE.
    assign stream   = (mode == SRC_STREAM);
    assign active   = cfg_en[i] && (mode == mode_q);
    assign prime_ok = (level >= prime_eff);
    assign ready    = active && stream && (st != IDLE) && !full;
    assign push     = s_valid[i] && ready;

    dac_sample_fifo #(.W(DW), .AW(FIFO_AW)) u_fifo (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (s_data[i]),
      .dout  (fifo_out),
      .level (level),
      .full  (full),
      .empty (empty)
    );

    // Channel next-state, FIFO control and next output sample.
    always_comb begin
      st_n   = st;
      pop    = 1'b0;
      flush  = 1'b0;
      under  = 1'b0;
      data_n = data_q;
      if (!active) begin
        st_n   = IDLE;
        flush  = 1'b1;
        data_n = MID;
      end else begin
        case (st)
          IDLE: begin
            flush  = 1'b1;
            data_n = MID;
            st_n   = stream ? PRIME : RUN;
          end
          PRIME, UNDERRUN: begin
            if (tick && prime_ok) begin
              st_n   = RUN;
              pop    = 1'b1;
              data_n = to_offset_bin(fifo_out, cfg_signed);
            end else begin
              st_n = st;
            end
          end
          RUN: begin
            if (!stream) begin
              flush  = 1'b1;
              data_n = tick ? static_val : data_q;
            end else if (!tick) begin
              st_n = RUN;
            end else if (!empty) begin
              pop    = 1'b1;
              data_n = to_offset_bin(fifo_out, cfg_signed);
            end else begin
              st_n   = UNDERRUN;
              under  = 1'b1;
              data_n = cfg_hold ? data_q : MID;
            end
          end
          default: begin
            st_n   = IDLE;
            flush  = 1'b1;
            data_n = MID;
          end
        endcase
      end
    end

    // Channel state, registered pin outputs and saturating underrun counter.
    always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
        st     <= IDLE;
        mode_q <= SRC_STREAM;
        data_q <= MID;
        wrt_q  <= 1'b0;
        ucnt_q <= '0;
      end else begin
        st     <= st_n;
        mode_q <= mode;
        data_q <= data_n;
        wrt_q  <= (st_n == RUN) || (st_n == UNDERRUN);
        if (ucnt_clr) begin
          ucnt_q <= '0;
        end else if (under && (ucnt_q != '1)) begin
          ucnt_q <= ucnt_q + UCNT_W'(1);
        end else begin
          ucnt_q <= ucnt_q;
        end
      end
    end

    assign ready_a[i] = ready;
    assign data_a[i]  = data_q;
    assign wrt_a[i]   = wrt_q;
    assign ucnt_a[i]  = ucnt_q;
    assign state_a[i] = st;
  end

endmodule

// File: tb/tb_dac_stream_scheduler.sv
// Directed scoreboard bench for dac_stream_scheduler (default build, ramp option off).
module tb_dac_stream_scheduler;

  localparam logic [13:0] MID = 14'h2000;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        s1_valid, s1_ready, s2_valid, s2_ready;
  logic [13:0] s1_data, s2_data;
  logic [1:0]  cfg_en, cfg_src;
  logic        cfg_signed, cfg_hold, ucnt_clr;
  logic [15:0] cfg_div;
  logic [4:0]  cfg_prime;
  logic [13:0] csr_data1, csr_data2, data1, data2;
  logic        wrt1_en, wrt2_en;
  logic [15:0] ucnt1, ucnt2;
  logic [1:0]  state1, state2;

  int          vectors = 0;
  int          miscompares = 0;
  logic [13:0] exp1_q[$];
  logic [13:0] last1 = 14'h2000;
  bit          mon_on = 1'b0;
  bit          per_ok = 1'b0;
  int          per_exp = 4;
  int          cyc = 0;
  int          last_cyc = 0;

  dac_stream_scheduler dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_data(s2_data),
    .cfg_en(cfg_en), .cfg_src(cfg_src), .cfg_signed(cfg_signed), .cfg_hold(cfg_hold),
    .cfg_div(cfg_div), .cfg_prime(cfg_prime), .csr_data1(csr_data1), .csr_data2(csr_data2),
`ifdef DAC_TEST_RAMP_EN
    .cfg_ramp(2'b00),
`endif
    .data1(data1), .wrt1_en(wrt1_en), .data2(data2), .wrt2_en(wrt2_en),
    .ucnt1(ucnt1), .ucnt2(ucnt2), .ucnt_clr(ucnt_clr), .state1(state1), .state2(state2)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [13:0] conv(input logic [13:0] d, input logic s);
    return s ? (d ^ 14'h2000) : d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic push1(input logic [13:0] d);
    int n;
    n = 0;
    s1_valid = 1'b1;
    s1_data  = d;
    while (s1_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) chk("push_timeout", 32'(s1_ready), 32'd1);
    else exp1_q.push_back(conv(d, cfg_signed));
    step();
    s1_valid = 1'b0;
  endtask

  task automatic drain1(input string tag);
    int n;
    n = 0;
    while (exp1_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(exp1_q.size()), 32'd0);
  endtask

  task automatic wait_state1(input logic [1:0] s, input string tag);
    int n;
    n = 0;
    while (state1 !== s && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(state1), 32'(s));
  endtask

  // Scoreboard monitor: every new ch1 output sample must match the next queued expectation.
  always @(negedge sys_clk) begin
    logic [13:0] e;
    cyc = cyc + 1;
    if (mon_on && wrt1_en === 1'b1 && data1 !== last1) begin
      if (exp1_q.size() == 0) begin
        chk("ch1_unexpected_sample", 32'(data1), 32'(last1));
      end else begin
        e = exp1_q.pop_front();
        chk("ch1_data", 32'(data1), 32'(e));
        if (per_ok) chk("ch1_period", 32'(cyc - last_cyc), 32'(per_exp));
        per_ok = 1'b1;
      end
      last_cyc = cyc;
    end
    last1 = data1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0; s1_data = '0; s2_data = '0;
    cfg_en = 2'b00; cfg_src = 2'b00; cfg_signed = 1'b0; cfg_hold = 1'b1; ucnt_clr = 1'b0;
    cfg_div = 16'd3; cfg_prime = 5'd4; csr_data1 = '0; csr_data2 = '0;
    step(); step();
    chk("rst_data1", 32'(data1), 32'(MID));
    chk("rst_wrt1", 32'(wrt1_en), 32'd0);
    chk("rst_ready1", 32'(s1_ready), 32'd0);
    chk("rst_ucnt1", 32'(ucnt1), 32'd0);
    chk("rst_state1", 32'(state1), 32'd0);
    chk("rst_data2", 32'(data2), 32'(MID));
    rst_n = 1'b1;
    step();

    // Stream ch1: prime 4, div 3, samples 0..7 every 4 clocks.
    cfg_en = 2'b01; mon_on = 1'b1; per_ok = 1'b0; per_exp = 4;
    for (int k = 0; k < 8; k++) push1(14'(k));
    drain1("drain_0_7");
    wait_state1(2'd3, "underrun_state");
    chk("underrun_ucnt1", 32'(ucnt1), 32'd1);
    chk("underrun_wrt1", 32'(wrt1_en), 32'd1);
    chk("hold_data1", 32'(data1), 32'd7);
    repeat (6) step();
    chk("hold_data1_later", 32'(data1), 32'd7);

    // Midscale on underrun, refill of 4 samples returns to RUN.
    cfg_hold = 1'b0; per_ok = 1'b0;
    for (int k = 8; k < 12; k++) push1(14'(k));
    exp1_q.push_back(MID);
    drain1("drain_refill");
    chk("refill_underrun_state", 32'(state1), 32'd3);
    chk("refill_ucnt1", 32'(ucnt1), 32'd2);

    // Signed conversion with prime 0 (treated as 1).
    cfg_signed = 1'b1; cfg_prime = 5'd0; per_ok = 1'b0;
    push1(14'h3FFF);
    push1(14'h0000);
    drain1("drain_signed");
    wait_state1(2'd3, "signed_underrun_state");
    chk("signed_ucnt1", 32'(ucnt1), 32'd3);
    ucnt_clr = 1'b1;
    step();
    ucnt_clr = 1'b0;
    chk("ucnt_clr", 32'(ucnt1), 32'd0);

    // Disable, then fill FIFO to 16 in PRIME with no tick.
    cfg_signed = 1'b0; cfg_prime = 5'd4; cfg_hold = 1'b1; cfg_div = 16'hFFFF; cfg_en = 2'b00;
    step();
    chk("dis_wrt1", 32'(wrt1_en), 32'd0);
    chk("dis_state1", 32'(state1), 32'd0);
    chk("dis_data1", 32'(data1), 32'(MID));
    cfg_en = 2'b01; per_ok = 1'b0; per_exp = 1;
    for (int k = 0; k < 16; k++) push1(14'h100 + 14'(k));
    s1_valid = 1'b1; s1_data = 14'h3AAA;
    chk("full_ready", 32'(s1_ready), 32'd0);
    step(); step();
    chk("full_ready_held", 32'(s1_ready), 32'd0);
    chk("full_state1", 32'(state1), 32'd1);
    s1_valid = 1'b0;
    cfg_div = 16'd0;
    drain1("drain_full");
    wait_state1(2'd3, "full_underrun_state");
    chk("full_last_data1", 32'(data1), 32'h10F);
    chk("full_ucnt1", 32'(ucnt1), 32'd1);

    // CSR static source on ch2, stream on ch1.
    cfg_div = 16'd3; cfg_en = 2'b00;
    step();
    cfg_src = 2'b10; csr_data2 = 14'h1234; cfg_en = 2'b11; per_ok = 1'b0; per_exp = 4;
    n = 0;
    while (wrt2_en !== 1'b1 && n < 8) begin step(); n++; end
    chk("csr_wrt2", 32'(wrt2_en), 32'd1);
    n = 0;
    while (data2 === MID && n < 8) begin step(); n++; end
    chk("csr_data2", 32'(data2), 32'h1234);
    chk("csr_state2", 32'(state2), 32'd2);
    chk("csr_ch1_state", 32'(state1), 32'd1);
    chk("csr_ch1_wrt", 32'(wrt1_en), 32'd0);
    for (int k = 0; k < 4; k++) push1(14'h0A1 + 14'(k));
    drain1("drain_csr_ch1");
    cfg_signed = 1'b1; csr_data2 = 14'h0ABC;
    n = 0;
    while (data2 === 14'h1234 && n < 8) begin step(); n++; end
    chk("csr_signed_data2", 32'(data2), 32'h2ABC);

    // Reset mid-RUN.
    chk("pre_rst_state2", 32'(state2), 32'd2);
    mon_on = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_data2", 32'(data2), 32'(MID));
    chk("midrst_wrt2", 32'(wrt2_en), 32'd0);
    chk("midrst_state2", 32'(state2), 32'd0);
    chk("midrst_ucnt1", 32'(ucnt1), 32'd0);
    chk("midrst_data1", 32'(data1), 32'(MID));

    // ch2 disable drops wrt on the next edge.
    n = 0;
    while (data2 !== 14'h2ABC && n < 12) begin step(); n++; end
    chk("rerun_data2", 32'(data2), 32'h2ABC);
    cfg_en = 2'b01;
    step();
    chk("dis2_wrt2", 32'(wrt2_en), 32'd0);
    chk("dis2_data2", 32'(data2), 32'(MID));
    chk("dis2_state2", 32'(state2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
